// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- pipeline sequencer for the 5-stage MIPS core.
//
// Purpose:
//   Generates the PC write enable, IF/ID load/flush, ID/EX bubble and global
//   freeze controls. It detects load-use and branch-in-ID data hazards and
//   schedules 1..3 cycle stalls through a registered 2-bit stall counter. It
//   flushes IF/ID on taken branches and jumps. It freezes the whole pipe while
//   data memory is busy. It bubbles IF/ID while instruction memory is busy.
//
// Per-cycle priority, highest first:
//   reset > freeze > stall > redirect > fetch wait > normal
//
// Optional feature:
//   HAZ_PERF_CNT_EN -- when defined, saturating stall and flush event
//   counters are built. When undefined, perf_stall and perf_flush read 0.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   id_rs, id_rt    source registers of the instruction in ID
//   id_uses_rt      the ID instruction reads rt
//   id_branch       the ID instruction is a conditional branch
//   branch_taken    branch comparator result
//   id_jump         the ID instruction is j/jal/jr
//   ex_mem_read     the EX instruction is a load
//   ex_reg_write    the EX instruction writes a register
//   ex_dst          destination register of the EX instruction
//   mem_mem_read    the MEM instruction is a load
//   mem_dst         destination register of the MEM instruction
//   imem_ready      fetch data valid
//   dmem_ready      data access complete
//   pc_load         PC write enable
//   ifid_load       IF/ID load enable
//   ifid_flush      IF/ID clear
//   idex_bubble     ID/EX NOP insert
//   pipe_freeze     global hold
//   stall_active    stall counter nonzero
//   perf_stall      stall cycle count
//   perf_flush      redirect count
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned LOAD_BR_STALL = 2,
  parameter int unsigned CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_branch,
  input  logic              branch_taken,
  input  logic              id_jump,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  output logic              pc_load,
  output logic              ifid_load,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic              stall_active,
  output logic [CNT_W-1:0]  perf_stall,
  output logic [CNT_W-1:0]  perf_flush
);

  localparam logic [1:0] LB_STALL = 2'(LOAD_BR_STALL);

  typedef enum logic [2:0] {
    M_RESET,
    M_FREEZE,
    M_STALL,
    M_REDIRECT,
    M_FETCH_WAIT,
    M_NORMAL
  } mode_t;

  mode_t      mode;
  logic [1:0] cnt;
  logic [1:0] need;
  logic       ex_hit;
  logic       mem_hit;

  // A producer matches when it targets a nonzero register read by ID.
  // Register r0 is hard-wired to zero, so it never creates a hazard.
  assign ex_hit  = (ex_dst != '0) &&
                   ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
  assign mem_hit = (mem_dst != '0) &&
                   ((mem_dst == id_rs) || (id_uses_rt && (mem_dst == id_rt)));

  // Required stall length is the largest matching term.
  // LB_STALL is at least 1, so applying it last yields the maximum.
  always_comb begin
    need = '0;
    if (ex_mem_read && ex_hit)                need = 2'd1;
    if (id_branch && ex_reg_write && ex_hit)  need = 2'd1;
    if (id_branch && mem_mem_read && mem_hit) need = 2'd1;
    if (id_branch && ex_mem_read && ex_hit)   need = LB_STALL;
  end

  // The memory stage only drops dmem_ready while an access is in flight.
  // A low dmem_ready is therefore always a real wait.
  always_comb begin
    mode = M_NORMAL;
    if (rst)                                       mode = M_RESET;
    else if (!dmem_ready)                          mode = M_FREEZE;
    else if ((cnt != '0) || (need != '0))          mode = M_STALL;
    else if (id_jump || (id_branch && branch_taken)) mode = M_REDIRECT;
    else if (!imem_ready)                          mode = M_FETCH_WAIT;
  end

  // While the counter is nonzero, hazard detection is masked.
  // The counter simply runs down to zero.
  always_ff @(posedge clk) begin
    case (mode)
      M_RESET:  cnt <= '0;
      M_FREEZE: cnt <= cnt;
      M_STALL:  cnt <= (cnt != '0) ? cnt - 2'd1 : need - 2'd1;
      default:  cnt <= '0;
    endcase
  end

  always_comb begin
    pc_load     = 1'b0;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    case (mode)
      M_RESET: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      M_FREEZE: pipe_freeze = 1'b1;
      M_STALL:  idex_bubble = 1'b1;
      M_REDIRECT: begin
        pc_load    = 1'b1;
        ifid_load  = 1'b1;
        ifid_flush = 1'b1;
      end
      // IF/ID captures a flushed slot so downstream keeps advancing.
      M_FETCH_WAIT: begin
        ifid_load  = 1'b1;
        ifid_flush = 1'b1;
      end
      default: begin
        pc_load   = 1'b1;
        ifid_load = 1'b1;
      end
    endcase
  end

  assign stall_active = !rst && (cnt != '0);

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if ((mode == M_STALL) && (perf_stall != '1))    perf_stall <= perf_stall + 1'b1;
      if ((mode == M_REDIRECT) && (perf_flush != '1)) perf_flush <= perf_flush + 1'b1;
    end
  end
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl.
// Stimulus pushes the expected outputs for each cycle into a queue.
// A negedge monitor pops each entry and compares it with the DUT outputs.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned LBS    = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] id_rs, id_rt, ex_dst, mem_dst;
  logic              id_uses_rt, id_branch, branch_taken, id_jump;
  logic              ex_mem_read, ex_reg_write, mem_mem_read;
  logic              imem_ready, dmem_ready;
  logic              pc_load, ifid_load, ifid_flush, idex_bubble;
  logic              pipe_freeze, stall_active;
  logic [CNT_W-1:0]  perf_stall, perf_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW),
    .LOAD_BR_STALL(LBS),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .branch_taken(branch_taken), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
    .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_load(pc_load), .ifid_load(ifid_load), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .stall_active(stall_active),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  // ctrl = {pc_load, ifid_load, ifid_flush, idex_bubble, pipe_freeze, stall_active}
  typedef struct {
    logic [5:0] ctrl;
    int unsigned ps;
    int unsigned pf;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: stall cycles still owed after the current one.
  // Event counts are kept as plain integers.
  int unsigned owed = 0;
  int unsigned ms   = 0;
  int unsigned mf   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("ctrl", {26'd0, pc_load, ifid_load, ifid_flush, idex_bubble, pipe_freeze, stall_active}, {26'd0, e.ctrl});
      chk("perf_stall", {28'd0, perf_stall}, e.ps);
      chk("perf_flush", {28'd0, perf_flush}, e.pf);
    end
  end

  function automatic bit hits(input logic [REG_AW-1:0] x);
    return (x != 0) && (x == id_rs || (id_uses_rt && x == id_rt));
  endfunction

  // Compute the expected response for the current inputs and enqueue it.
  // Then advance one clock and update the reference state.
  task automatic step();
    exp_t e;
    int unsigned need;
    bit stall, redir;
    need = 0;
    if (ex_mem_read && hits(ex_dst))                need = 1;
    if (id_branch && ex_reg_write && hits(ex_dst))  need = (need > 1) ? need : 1;
    if (id_branch && mem_mem_read && hits(mem_dst)) need = (need > 1) ? need : 1;
    if (id_branch && ex_mem_read && hits(ex_dst))   need = (need > LBS) ? need : LBS;
    stall = (owed > 0) || (need > 0);
    redir = id_jump || (id_branch && branch_taken);
    if (rst)             e.ctrl = 6'b001100;
    else if (!dmem_ready) e.ctrl = {5'b00001, owed > 0};
    else if (stall)      e.ctrl = {5'b00010, owed > 0};
    else if (redir)      e.ctrl = 6'b111000;
    else if (!imem_ready) e.ctrl = 6'b011000;
    else                 e.ctrl = 6'b110000;
`ifdef HAZ_PERF_CNT_EN
    e.ps = ms;
    e.pf = mf;
`else
    e.ps = 0;
    e.pf = 0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    if (rst) begin
      owed = 0; ms = 0; mf = 0;
    end else if (dmem_ready) begin
      if (stall) begin
        owed = (owed > 0) ? owed - 1 : need - 1;
        if (ms < CMAX) ms++;
      end else if (redir) begin
        if (mf < CMAX) mf++;
      end
    end
    #1;
  endtask

  task automatic neutral();
    rst = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_branch = 0;
    branch_taken = 0; id_jump = 0; ex_mem_read = 0; ex_reg_write = 0;
    ex_dst = 0; mem_mem_read = 0; mem_dst = 0; imem_ready = 1; dmem_ready = 1;
  endtask

  initial begin
    neutral();
    rst = 1;
    @(posedge clk); #1;
    step(); step();                              // reset held
    neutral(); step();                           // normal after reset

    // Load-use: one stall, then normal.
    ex_mem_read = 1; ex_dst = 8; id_rs = 8; step();
    neutral(); id_rs = 8; step();

    // Branch on a load result: two stalls, then the taken redirect.
    ex_mem_read = 1; ex_dst = 9; id_rs = 9; id_branch = 1; step(); step();
    neutral(); id_branch = 1; id_rs = 9; branch_taken = 1; step();
    neutral(); step();

    // r0 never stalls.
    ex_mem_read = 1; ex_dst = 0; id_rs = 0; step();

    // Freeze during an active stall holds the counter.
    neutral(); ex_mem_read = 1; ex_dst = 9; id_rs = 9; id_branch = 1; step();
    dmem_ready = 0; step(); step(); step();
    dmem_ready = 1; step();
    neutral(); step();

    // A jump beats a fetch wait; then a bare fetch wait.
    id_jump = 1; imem_ready = 0; step();
    id_jump = 0; step();
    neutral();

    // Reset in the middle of a stall.
    ex_mem_read = 1; ex_dst = 5; id_rt = 5; id_uses_rt = 1; id_branch = 1; step();
    rst = 1; step();
    neutral(); step();

    // Random traffic on a small register set so hazards are frequent.
    for (int i = 0; i < 2500; i++) begin
      rst          = ($urandom_range(0, 99) < 2);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom);
      id_branch    = ($urandom_range(0, 99) < 35);
      branch_taken = 1'($urandom);
      id_jump      = ($urandom_range(0, 99) < 10);
      ex_mem_read  = ($urandom_range(0, 99) < 30);
      ex_reg_write = 1'($urandom);
      ex_dst       = 5'($urandom_range(0, 3));
      mem_mem_read = ($urandom_range(0, 99) < 30);
      mem_dst      = 5'($urandom_range(0, 3));
      imem_ready   = ($urandom_range(0, 99) < 80);
      dmem_ready   = ($urandom_range(0, 99) < 85);
      step();
    end

    for (int k = 0; k < 4 && sbq.size() > 0; k++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
